// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Brief    : Round-robin writeback arbiter. Grants one execution-pipe record
//             per cycle and registers it into a single output record that
//             feeds the regfile write port, wakeup and ROB completion.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
   parameter  int NUM_SRC = 4,
   parameter  int DATA_W  = 32,
   parameter  int PREG_W  = 6,
   parameter  int ROB_W   = 6,
   localparam int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush_i,
   input  logic [NUM_SRC-1:0]        src_valid_i,
   input  logic [NUM_SRC-1:0]        src_we_i,
   input  logic [NUM_SRC*DATA_W-1:0] src_wdata_i,
   input  logic [NUM_SRC*PREG_W-1:0] src_pdest_i,
   input  logic [NUM_SRC*ROB_W-1:0]  src_rob_idx_i,
   output logic [NUM_SRC-1:0]        src_ready_o,
   output logic                      out_valid_o,
   output logic                      out_we_o,
   output logic [DATA_W-1:0]         out_wdata_o,
   output logic [PREG_W-1:0]         out_pdest_o,
   output logic [ROB_W-1:0]          out_rob_idx_o,
   output logic [SRC_W-1:0]          out_src_o,
   input  logic                      out_ready_i,
   output logic [31:0]               conflict_cnt_o
);

   localparam logic [SRC_W-1:0] c_last_src = SRC_W'(NUM_SRC - 1);
   localparam logic [31:0]      c_cnt_max  = 32'hFFFF_FFFF;

   logic [SRC_W-1:0]   r_rr_ptr;
   logic               r_out_valid;
   logic               r_out_we;
   logic [DATA_W-1:0]  r_out_wdata;
   logic [PREG_W-1:0]  r_out_pdest;
   logic [ROB_W-1:0]   r_out_rob_idx;
   logic [SRC_W-1:0]   r_out_src;
   logic [31:0]        r_conflict_cnt;

   logic [NUM_SRC-1:0] w_win;
   logic [SRC_W-1:0]   w_win_idx;
   logic               w_any;
   logic               w_can_accept;
   logic               w_xfer;
   logic               w_conflict;
   logic [SRC_W-1:0]   w_rr_next;
   logic [DATA_W-1:0]  w_sel_wdata;
   logic [PREG_W-1:0]  w_sel_pdest;
   logic [ROB_W-1:0]   w_sel_rob_idx;

   // Round-robin scan starting at r_rr_ptr; the first valid source wins.
   always_comb begin
      int v_idx;
      w_win     = '0;
      w_win_idx = '0;
      w_any     = 1'b0;
      v_idx     = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         v_idx = int'(r_rr_ptr) + k;
         if (v_idx >= NUM_SRC) begin
            v_idx = v_idx - NUM_SRC;
         end
         if (!w_any && src_valid_i[v_idx]) begin
            w_any        = 1'b1;
            w_win[v_idx] = 1'b1;
            w_win_idx    = SRC_W'(v_idx);
         end
      end
   end

   // Conflict detection: two or more sources requesting in the same cycle.
   always_comb begin
      int v_cnt;
      v_cnt = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_valid_i[k]) begin
            v_cnt = v_cnt + 1;
         end
      end
      w_conflict = (v_cnt >= 2);
   end

   // The output slot can take a new record when it is empty or draining,
   // and never while a flush is in progress.
   assign w_can_accept  = (~r_out_valid | out_ready_i) & ~flush_i;
   assign src_ready_o   = w_win & {NUM_SRC{w_can_accept}};
   assign w_xfer        = w_any & w_can_accept;
   assign w_rr_next     = (w_win_idx == c_last_src) ? '0 : w_win_idx + SRC_W'(1);

   assign w_sel_wdata   = src_wdata_i  [int'(w_win_idx)*DATA_W +: DATA_W];
   assign w_sel_pdest   = src_pdest_i  [int'(w_win_idx)*PREG_W +: PREG_W];
   assign w_sel_rob_idx = src_rob_idx_i[int'(w_win_idx)*ROB_W  +: ROB_W];

   // Output record register: flush kills it, a transfer overwrites it
   // (even while draining), otherwise a consumed record empties the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_we      <= 1'b0;
         r_out_wdata   <= '0;
         r_out_pdest   <= '0;
         r_out_rob_idx <= '0;
         r_out_src     <= '0;
         r_rr_ptr      <= '0;
      end else if (flush_i) begin
         r_out_valid   <= 1'b0;
         r_out_we      <= 1'b0;
      end else if (w_xfer) begin
         r_out_valid   <= 1'b1;
         r_out_we      <= src_we_i[w_win_idx];
         r_out_wdata   <= w_sel_wdata;
         r_out_pdest   <= w_sel_pdest;
         r_out_rob_idx <= w_sel_rob_idx;
         r_out_src     <= w_win_idx;
         r_rr_ptr      <= w_rr_next;
      end else if (out_ready_i) begin
         r_out_valid   <= 1'b0;
      end
   end

   // Saturating conflict counter; counts regardless of flush or stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != c_cnt_max)) begin
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   assign out_valid_o    = r_out_valid;
   assign out_we_o       = r_out_we;
   assign out_wdata_o    = r_out_wdata;
   assign out_pdest_o    = r_out_pdest;
   assign out_rob_idx_o  = r_out_rob_idx;
   assign out_src_o      = r_out_src;
   assign conflict_cnt_o = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Brief    : Directed-vector scoreboard bench for wb_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] wdata;
      logic [5:0]  pdest;
      logic [5:0]  rob;
      logic [1:0]  src;
   } rec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush_i = 1'b0;
   logic [3:0]   src_valid_i = '0;
   logic [3:0]   src_we_i = '0;
   logic [127:0] src_wdata_i = '0;
   logic [23:0]  src_pdest_i = '0;
   logic [23:0]  src_rob_idx_i = '0;
   logic [3:0]   src_ready_o;
   logic         out_valid_o;
   logic         out_we_o;
   logic [31:0]  out_wdata_o;
   logic [5:0]   out_pdest_o;
   logic [5:0]   out_rob_idx_o;
   logic [1:0]   out_src_o;
   logic         out_ready_i = 1'b0;
   logic [31:0]  conflict_cnt_o;

   int   n_vec = 0;
   int   n_err = 0;
   rec_t exp_q[$];

   wb_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush_i        (flush_i),
      .src_valid_i    (src_valid_i),
      .src_we_i       (src_we_i),
      .src_wdata_i    (src_wdata_i),
      .src_pdest_i    (src_pdest_i),
      .src_rob_idx_i  (src_rob_idx_i),
      .src_ready_o    (src_ready_o),
      .out_valid_o    (out_valid_o),
      .out_we_o       (out_we_o),
      .out_wdata_o    (out_wdata_o),
      .out_pdest_o    (out_pdest_o),
      .out_rob_idx_o  (out_rob_idx_o),
      .out_src_o      (out_src_o),
      .out_ready_i    (out_ready_i),
      .conflict_cnt_o (conflict_cnt_o)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_src(input int i, input logic v, input logic we,
                          input logic [31:0] d, input logic [5:0] p, input logic [5:0] r);
      src_valid_i[i]            = v;
      src_we_i[i]               = we;
      src_wdata_i[i*32 +: 32]   = d;
      src_pdest_i[i*6 +: 6]     = p;
      src_rob_idx_i[i*6 +: 6]   = r;
   endtask

   task automatic push(input logic we, input logic [31:0] d, input logic [5:0] p,
                       input logic [5:0] r, input logic [1:0] s);
      rec_t e;
      e.we = we; e.wdata = d; e.pdest = p; e.rob = r; e.src = s;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      src_valid_i = '0;
      flush_i     = 1'b0;
      out_ready_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every record consumed by the downstream side is checked
   // against the head of the expected queue.
   always begin
      rec_t e;
      @(negedge clk);
      #2;
      if (rst_n && out_valid_o && out_ready_i && !flush_i) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rec: unexpected record src=%0d wdata=%0h", out_src_o, out_wdata_o);
         end else begin
            e = exp_q.pop_front();
            if ({out_we_o, out_wdata_o, out_pdest_o, out_rob_idx_o, out_src_o} !== e) begin
               n_err++;
               $display("FAIL rec: got we=%0b wdata=%0h pdest=%0d rob=%0d src=%0d expected we=%0b wdata=%0h pdest=%0d rob=%0d src=%0d",
                        out_we_o, out_wdata_o, out_pdest_o, out_rob_idx_o, out_src_o,
                        e.we, e.wdata, e.pdest, e.rob, e.src);
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Directed stimulus.
   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_fields", 64'({out_we_o, out_wdata_o, out_pdest_o, out_rob_idx_o, out_src_o}), 64'd0);
      chk("rst_cnt", 64'(conflict_cnt_o), 64'd0);
      chk("rst_ready", 64'(src_ready_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single source 2.
      @(negedge clk);
      set_src(2, 1'b1, 1'b1, 32'hDEAD_BEEF, 6'd17, 6'd5);
      out_ready_i = 1'b1;
      push(1'b1, 32'hDEAD_BEEF, 6'd17, 6'd5, 2'd2);
      #1 chk("single_ready", 64'(src_ready_o), 64'b0100);
      @(negedge clk);
      src_valid_i[2] = 1'b0;
      #1 chk("single_valid", 64'(out_valid_o), 64'd1);
      @(negedge clk);
      #1 chk("single_drain", 64'(out_valid_o), 64'd0);

      // All four sources continuously valid: strict rotation, no bubbles.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin
            for (int i = 0; i < 4; i++) begin
               set_src(i, 1'b1, 1'b1, 32'hA000_0000 + 32'(i), 6'(10 + i), 6'(20 + i));
            end
            out_ready_i = 1'b1;
         end
         push(1'b1, 32'hA000_0000 + 32'(k % 4), 6'(10 + k % 4), 6'(20 + k % 4), 2'(k % 4));
         #1 chk($sformatf("rr_ready_%0d", k), 64'(src_ready_o), 64'(4'b0001 << (k % 4)));
      end
      @(negedge clk);
      src_valid_i = '0;
      #1 chk("rr_conflicts", 64'(conflict_cnt_o), 64'd8);

      // Backpressure: sources 1 and 3, output stalled for 3 cycles.
      do_reset();
      @(negedge clk);
      set_src(1, 1'b1, 1'b1, 32'h1111_1111, 6'd33, 6'd11);
      set_src(3, 1'b1, 1'b1, 32'h3333_3333, 6'd35, 6'd13);
      out_ready_i = 1'b1;
      push(1'b1, 32'h1111_1111, 6'd33, 6'd11, 2'd1);
      #1 chk("bp_grant1", 64'(src_ready_o), 64'b0010);
      @(negedge clk);
      src_valid_i[1] = 1'b0;
      out_ready_i    = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready_zero", 64'(src_ready_o), 64'd0);
         chk("bp_hold", 64'({out_valid_o, out_src_o, out_wdata_o}), 64'({1'b1, 2'd1, 32'h1111_1111}));
         @(negedge clk);
      end
      out_ready_i = 1'b1;
      push(1'b1, 32'h3333_3333, 6'd35, 6'd13, 2'd3);
      #1 chk("bp_grant3", 64'(src_ready_o), 64'b1000);
      @(negedge clk);
      src_valid_i[3] = 1'b0;
      @(negedge clk);

      // Flush while output held; rr_ptr is 0 here.
      set_src(2, 1'b1, 1'b1, 32'h2222_2222, 6'd34, 6'd12);
      out_ready_i = 1'b0;
      #1 chk("fl_pre_grant", 64'(src_ready_o), 64'b0100);
      @(negedge clk);
      src_valid_i[2] = 1'b0;
      set_src(0, 1'b1, 1'b1, 32'h0000_0A0A, 6'd40, 6'd20);
      flush_i = 1'b1;
      #1;
      chk("fl_held_valid", 64'(out_valid_o), 64'd1);
      chk("fl_ready_zero", 64'(src_ready_o), 64'd0);
      @(negedge clk);
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      push(1'b1, 32'h0000_0A0A, 6'd40, 6'd20, 2'd0);
      #1;
      chk("fl_killed", 64'({out_valid_o, out_we_o}), 64'd0);
      chk("fl_grant0", 64'(src_ready_o), 64'b0001);
      @(negedge clk);
      src_valid_i[0] = 1'b0;
      @(negedge clk);

      // we=0 record still completes in the ROB.
      set_src(0, 1'b1, 1'b0, 32'h0000_5555, 6'd41, 6'd9);
      push(1'b0, 32'h0000_5555, 6'd41, 6'd9, 2'd0);
      #1 chk("nowe_grant", 64'(src_ready_o), 64'b0001);
      @(negedge clk);
      src_valid_i[0] = 1'b0;
      #1 chk("nowe_out", 64'({out_valid_o, out_we_o, out_rob_idx_o}), 64'({1'b1, 1'b0, 6'd9}));
      @(negedge clk);

      // Counter saturation.
      force dut.r_conflict_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_conflict_cnt;
      #1 chk("sat_preset", 64'(conflict_cnt_o), 64'hFFFF_FFFE);
      @(negedge clk);
      set_src(1, 1'b1, 1'b1, 32'h7777_0001, 6'd50, 6'd30);
      set_src(2, 1'b1, 1'b1, 32'h7777_0002, 6'd51, 6'd31);
      flush_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk($sformatf("sat_cnt_%0d", k), 64'(conflict_cnt_o), 64'hFFFF_FFFF);
      end
      flush_i        = 1'b0;
      src_valid_i[2] = 1'b0;
      #1 chk("rst_mid_grant", 64'(src_ready_o), 64'b0010);

      // Asynchronous reset with a record in flight.
      @(posedge clk);
      #2 chk("rst_mid_pre", 64'(out_valid_o), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out", 64'({out_valid_o, out_we_o, out_wdata_o, out_pdest_o, out_rob_idx_o, out_src_o}), 64'd0);
      chk("rst_mid_cnt", 64'(conflict_cnt_o), 64'd0);
      @(negedge clk);
      src_valid_i = '0;
      rst_n       = 1'b1;
      @(negedge clk);
      #3 chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter directly downstream of the integer execution pipes (ALU, MUL, DIV, ...).
- Each pipe presents a registered writeback record under a valid/ready handshake.
- The block grants one source per cycle by round-robin and registers the winner into a single output record.
- The output record drives the physical regfile write port, wakeup broadcast and ROB completion.

Parameters:
- NUM_SRC, 4, number of execution pipes competing for the port (>=2)
- DATA_W, 32, writeback data width
- PREG_W, 6, physical register index width
- ROB_W, 6, ROB index width
- SRC_W, $clog2(NUM_SRC), source id width (derived, not overridable)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- flush_i  input  1  pipeline flush, synchronous
- src_valid_i  input  NUM_SRC  per-source record valid
- src_we_i  input  NUM_SRC  per-source regfile write enable
- src_wdata_i  input  NUM_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
- src_pdest_i  input  NUM_SRC*PREG_W  per-source destination preg, packed as above
- src_rob_idx_i  input  NUM_SRC*ROB_W  per-source ROB index, packed as above
- src_ready_o  output  NUM_SRC  per-source accept; one-hot or zero
- out_valid_o  output  1  output record valid
- out_we_o  output  1  regfile write enable (qualified by out_valid_o)
- out_wdata_o  output  DATA_W  write data
- out_pdest_o  output  PREG_W  destination preg
- out_rob_idx_o  output  ROB_W  ROB index to mark complete
- out_src_o  output  SRC_W  id of the source that produced the record
- out_ready_i  input  1  consumer accepts output record
- conflict_cnt_o  output  32  saturating count of cycles with >=2 sources valid

Behaviour:
- Reset: out_valid_o=0, out_we_o=0, out_wdata_o=0, out_pdest_o=0, out_rob_idx_o=0, out_src_o=0, conflict_cnt_o=0, rr_ptr=0. src_ready_o is combinational and reads 0 while out_valid_o=0 and no source is valid.
- can_accept = (~out_valid_o | out_ready_i) & ~flush_i.
- Grant (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - The first index with src_valid_i set wins.
  - src_ready_o[i] = win[i] & can_accept.
  - Grant depends only on valid inputs and block state, never on src_ready_o.
- Transfer: occurs when some src_ready_o[i]=1. On the next edge:
  - The output registers load source i's we/wdata/pdest/rob_idx, set out_src_o=i and out_valid_o=1.
  - rr_ptr <= (i+1) mod NUM_SRC.
- Latency: exactly 1 cycle from accepted input to out_valid_o.
- Throughput: 1 record/cycle while out_ready_i=1.
- Output held: while out_valid_o=1 and out_ready_i=0, all out_* fields stay stable and every src_ready_o=0.
- Output drain: if out_valid_o=1, out_ready_i=1 and no source is valid, out_valid_o <= 0. Data fields may hold stale values.
- Simultaneous drain and load: the output register is overwritten in the same cycle, with no bubble.
- rr_ptr changes only on a transfer. A lone valid source does not move priority toward others beyond the rule above.
- Sources must hold their record stable until accepted. The block does not check this.
- out_we_o=0 records still occupy the port and still report ROB completion.
- flush_i=1:
  - src_ready_o=0.
  - out_valid_o <= 0 and out_we_o <= 0 on the next edge.
  - rr_ptr and conflict_cnt_o unchanged.
  - Flush overrides out_ready_i.
- conflict_cnt_o:
  - +1 on any cycle with popcount(src_valid_i) >= 2, independent of can_accept and flush.
  - Saturates at 32'hFFFF_FFFF; no wrap.
- Reset asserted mid-operation: all state returns to reset values asynchronously, and any in-flight output record is dropped.
- Fairness: with all sources continuously valid and out_ready_i=1, grants cycle 0,1,...,NUM_SRC-1,0. Each source waits at most NUM_SRC-1 accepted transfers.

Test Plan:
- Reset then single source 2 valid: we=1, wdata=32'hDEAD_BEEF, pdest=17, rob=5, out_ready_i=1 -> src_ready_o=4'b0100 same cycle. Next cycle out_valid_o=1, out_wdata_o=DEAD_BEEF, out_pdest_o=17, out_rob_idx_o=5, out_src_o=2. Following cycle out_valid_o=0.
- All 4 sources held valid, out_ready_i=1 for 8 cycles -> out_src_o sequence 0,1,2,3,0,1,2,3, no bubbles; conflict_cnt_o=8.
- Sources 1 and 3 valid, out_ready_i=0 for 3 cycles after the first grant -> source 1 granted. out_* frozen and src_ready_o=0 for 3 cycles. Then source 3 granted on the cycle out_ready_i returns to 1.
- Output valid with out_ready_i=0, assert flush_i with source 0 valid -> src_ready_o=0. Next cycle out_valid_o=0. rr_ptr unchanged; source 0 is granted on the cycle after flush deasserts.
- Source 0 valid with we=0, rob=9 -> out_valid_o=1, out_we_o=0, out_rob_idx_o=9.
- Force conflict_cnt_o to 32'hFFFF_FFFE, then 3 conflict cycles -> value FFFF_FFFF and stays. Then assert rst_n=0 mid-transfer -> all outputs 0 immediately.
